// File: rtl/alu_share_arbiter_pkg.sv
// Shared types and constants for the ALU sharing sequencer and its surroundings.
package alu_ctrl_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int ALU_W   = 16;
    localparam int ALU_OPW = 3;

    localparam logic [ALU_OPW-1:0] OP_ADD  = 3'b000;
    localparam logic [ALU_OPW-1:0] OP_SUB  = 3'b001;
    localparam logic [ALU_OPW-1:0] OP_AND  = 3'b010;
    localparam logic [ALU_OPW-1:0] OP_OR   = 3'b011;
    localparam logic [ALU_OPW-1:0] OP_XOR  = 3'b100;
    localparam logic [ALU_OPW-1:0] OP_SHL  = 3'b101;
    localparam logic [ALU_OPW-1:0] OP_SHR  = 3'b110;
    localparam logic [ALU_OPW-1:0] OP_PASS = 3'b111;
endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request, ALU and response signals between issue logic, the shared ALU and the sequencer.
interface alu_share_arbiter_if
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = ALU_W,
    parameter int OPW   = ALU_OPW
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [WIDTH-1:0] req_a0;
    logic [WIDTH-1:0] req_b0;
    logic [WIDTH-1:0] req_a1;
    logic [WIDTH-1:0] req_b1;
    logic [OPW-1:0]   req_op0;
    logic [OPW-1:0]   req_op1;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [OPW-1:0]   alu_op;
    logic [WIDTH-1:0] alu_result;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_id;

    modport slave (
        input  req_valid, req_a0, req_b0, req_a1, req_b1, req_op0, req_op1,
        input  alu_result, rsp_ready,
        output req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_data, rsp_id
    );

    modport master (
        output req_valid, req_a0, req_b0, req_a1, req_b1, req_op0, req_op1,
        output alu_result, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_data, rsp_id
    );
endinterface

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin grant; the winner of a tie is the requester not served last.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt,
    output logic       gnt_idx
);
    always_comb begin
        gnt_idx = 1'b0;
        case (req)
            2'b01:   gnt_idx = 1'b0;
            2'b10:   gnt_idx = 1'b1;
            2'b11:   gnt_idx = ~last;
            default: gnt_idx = 1'b0;
        endcase
        gnt = (req == 2'b00) ? 2'b00 : (gnt_idx ? 2'b10 : 2'b01);
    end
endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters: grant, latch operands,
// capture the result one cycle later and hold it until the consumer takes it.
module alu_share_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = ALU_W,
    parameter int OPW   = ALU_OPW
) (
    input logic                clk,
    input logic                reset,
    alu_share_arbiter_if.slave bus
);
    state_e           state_q, state_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [OPW-1:0]   op_code_q, op_code_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_id_q, rsp_id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [1:0]       req_ready;
    logic [1:0]       gnt;
    logic             gnt_idx;

    rr_arb2 u_arb (
        .req     (bus.req_valid),
        .last    (last_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_code_d   = op_code_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        rsp_valid_d = rsp_valid_q;
        req_ready   = 2'b00;
        case (state_q)
            IDLE: begin
                // A non-zero grant in IDLE is itself the accept: ready mirrors the grant.
                req_ready = gnt;
                if (gnt != 2'b00) begin
                    op_a_d    = gnt_idx ? bus.req_a1  : bus.req_a0;
                    op_b_d    = gnt_idx ? bus.req_b1  : bus.req_b0;
                    op_code_d = gnt_idx ? bus.req_op1 : bus.req_op0;
                    rsp_id_d  = gnt_idx;
                    last_d    = gnt_idx;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d  = bus.alu_result;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_code_q   <= '0;
            rsp_data_q  <= '0;
            rsp_id_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_code_q   <= op_code_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // ALU inputs come straight from the operand latches so they only move on an accept.
    assign bus.alu_a     = op_a_q;
    assign bus.alu_b     = op_b_q;
    assign bus.alu_op    = op_code_q;
    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;
endmodule
